qracc_mac_sequencer: RTL and testbench

- Synthesizable bit-serial MAC controller that sits between a vector source and qr_acc_wrapper's MAC port.
- Accepts one multi-bit two's-complement input vector per handshake and drives it to the array one bit-plane at a time on data_p/data_n.
- Samples the per-column ADC codes and shift-accumulates them into full-precision signed column sums, returned over a valid/ready port.
- Generalises the fixed ternary, 1-plane MAC flow to 1..xBits planes, with signed/unsigned mode and configurable ADC latency.

---
 rtl/qracc_pkg.sv | 32 +++
 rtl/qracc_shift_acc.sv | 73 +++++++
 rtl/qracc_mac_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_qracc_mac_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// -----------------------------------------------------------------------------
// qracc_pkg
//   Shared types and helpers for the QR-accumulator MAC sequencer.
//   - seq_state_t      : sequencer FSM states
//   - qracc_seq_cfg_t  : per-vector configuration latched on accept
//   - calc_acc_bits()  : full-precision column accumulator width
//   No ports (package).
// -----------------------------------------------------------------------------
package qracc_pkg;

    localparam int CfgNBits = 8;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_SETTLE = 3'd1,
        S_IDLE   = 3'd2,
        S_DRIVE  = 3'd3,
        S_OUT    = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [CfgNBits-1:0] n_input_bits;   // already clamped to 1..xBits
        logic                signed_mode;
    } qracc_seq_cfg_t;

    // One extra bit over code width + plane count covers the worst-case
    // sum of n shifted signed codes.
    function automatic int calc_acc_bits(input int adc_bits, input int x_bits);
        return adc_bits + x_bits + 1;
    endfunction

endpackage

// File: rtl/qracc_shift_acc.sv
// -----------------------------------------------------------------------------
// qracc_shift_acc
//   One signed column accumulator: acc +/-= sext(adc) << shift.
//   Optional output saturation when QRACC_SEQ_SAT_EN is defined.
//   Ports:
//     clk, nrst      clock, asynchronous active-low reset
//     clr_i          clear accumulator (takes priority over en_i)
//     en_i           accumulate this cycle
//     sub_i          subtract instead of add
//     shift_i        plane index / shift amount
//     adc_i          signed ADC code
//     res_o          column result (full width, or saturated to outBits)
//     clip_o         (QRACC_SEQ_SAT_EN only) result is clipped
// -----------------------------------------------------------------------------
module qracc_shift_acc #(
    parameter int adcBits   = 4,
    parameter int accBits   = 9,
    parameter int shiftBits = 2
`ifdef QRACC_SEQ_SAT_EN
    , parameter int outBits = 8
`endif
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 sub_i,
    input  logic [shiftBits-1:0] shift_i,
    input  logic [adcBits-1:0]   adc_i,
`ifdef QRACC_SEQ_SAT_EN
    output logic [outBits-1:0]   res_o,
    output logic                 clip_o
`else
    output logic [accBits-1:0]   res_o
`endif
);

    logic signed [accBits-1:0] acc_q;
    logic signed [accBits-1:0] term;

    assign term = accBits'($signed(adc_i)) <<< shift_i;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sub_i ? (acc_q - term) : (acc_q + term);
        end
    end

`ifdef QRACC_SEQ_SAT_EN
    localparam int SatMaxI = (1 << (outBits - 1)) - 1;
    localparam logic signed [accBits-1:0] SatMax = accBits'(SatMaxI);
    localparam logic signed [accBits-1:0] SatMin = accBits'(-SatMaxI - 1);

    always_comb begin
        clip_o = 1'b0;
        res_o  = acc_q[outBits-1:0];
        if (acc_q > SatMax) begin
            clip_o = 1'b1;
            res_o  = SatMax[outBits-1:0];
        end else if (acc_q < SatMin) begin
            clip_o = 1'b1;
            res_o  = SatMin[outBits-1:0];
        end
    end
`else
    assign res_o = acc_q;
`endif

endmodule

// File: rtl/qracc_mac_sequencer.sv
// -----------------------------------------------------------------------------
// qracc_mac_sequencer
//   Bit-serial MAC controller in front of qr_acc_wrapper's MAC port. Accepts
//   one multi-bit two's-complement vector per handshake, drives it one
//   bit-plane at a time on data_p_o, and shift-accumulates the per-column ADC
//   codes into signed column sums returned over a valid/ready port.
//   Optional build macro: QRACC_SEQ_SAT_EN (saturated outBits results + sat_o).
//   Ports:
//     clk, nrst          clock, asynchronous active-low reset
//     enable_i           subsystem enable
//     n_input_bits_cfg   planes per vector (0 -> 1, >xBits -> xBits)
//     signed_cfg         MSB plane weighted negative
//     x_valid_i/x_ready_o/x_data_i   input vector handshake
//     mac_en_o           wrapper MAC enable
//     data_p_o/data_n_o  plane drive bits (data_n_o always 0)
//     adc_i              per-column signed ADC codes
//     res_valid_o/res_ready_i/res_data_o   column-sum handshake
//     sat_o              (QRACC_SEQ_SAT_EN only) sticky clip flag
//     busy_o             vector in flight or settling
// -----------------------------------------------------------------------------
module qracc_mac_sequencer
    import qracc_pkg::*;
#(
    parameter int numRows      = 128,
    parameter int numCols      = 32,
    parameter int xBits        = 4,
    parameter int numAdcBits   = 4,
    parameter int numCfgBits   = 8,
    parameter int adcLat       = 1,
    parameter int settleCycles = 5,
    parameter int accBits      = calc_acc_bits(numAdcBits, xBits)
`ifdef QRACC_SEQ_SAT_EN
    , parameter int outBits    = 8
`endif
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          enable_i,
    input  logic [numCfgBits-1:0]         n_input_bits_cfg,
    input  logic                          signed_cfg,
    input  logic                          x_valid_i,
    output logic                          x_ready_o,
    input  logic [numRows*xBits-1:0]      x_data_i,
    output logic                          mac_en_o,
    output logic [numRows-1:0]            data_p_o,
    output logic [numRows-1:0]            data_n_o,
    input  logic [numCols*numAdcBits-1:0] adc_i,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
`ifdef QRACC_SEQ_SAT_EN
    output logic [numCols*outBits-1:0]    res_data_o,
    output logic                          sat_o,
`else
    output logic [numCols*accBits-1:0]    res_data_o,
`endif
    output logic                          busy_o
);

    localparam int KW = (xBits > 1) ? $clog2(xBits) : 1;
`ifdef QRACC_SEQ_SAT_EN
    localparam int ResW = outBits;
`else
    localparam int ResW = accBits;
`endif

    seq_state_t                 state_q, state_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [KW-1:0]              k_q, k_d;
    qracc_seq_cfg_t             cfg_q, cfg_d;
    logic [numRows*xBits-1:0]   x_q, x_d;
    logic [CfgNBits-1:0]        n_clamped;
    logic                       last_plane;
    logic                       acc_clr, acc_en, acc_sub;

    always_comb begin
        n_clamped = CfgNBits'(n_input_bits_cfg);
        if (n_input_bits_cfg == '0) begin
            n_clamped = CfgNBits'(1);
        end else if (32'(n_input_bits_cfg) > 32'(xBits)) begin
            n_clamped = CfgNBits'(xBits);
        end
    end

    assign last_plane = (CfgNBits'(k_q) == (cfg_q.n_input_bits - CfgNBits'(1)));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            k_q     <= '0;
            cfg_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            cfg_q   <= cfg_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        cfg_d   = cfg_q;
        x_d     = x_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        acc_sub = 1'b0;
        case (state_q)
            S_OFF: begin
                cnt_d = '0;
                if (enable_i) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (!enable_i) begin
                    state_d = S_OFF;
                end else if (cnt_q == 16'(settleCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_IDLE: begin
                if (!enable_i) begin
                    state_d = S_OFF;
                end else if (x_valid_i) begin
                    x_d                = x_data_i;
                    cfg_d.n_input_bits = n_clamped;
                    cfg_d.signed_mode  = signed_cfg;
                    acc_clr            = 1'b1;
                    k_d                = '0;
                    cnt_d              = '0;
                    state_d            = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (!enable_i) begin
                    state_d = S_OFF;
                end else if (cnt_q == 16'(adcLat - 1)) begin
                    // Last cycle of the plane window: ADC code is valid now.
                    acc_en  = 1'b1;
                    acc_sub = cfg_q.signed_mode & last_plane;
                    cnt_d   = '0;
                    if (last_plane) state_d = S_OUT;
                    else            k_d     = k_q + KW'(1);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_OUT: begin
                // Result handshake completes even if enable drops.
                if (res_ready_i) state_d = enable_i ? S_IDLE : S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    assign mac_en_o    = (state_q != S_OFF);
    assign x_ready_o   = (state_q == S_IDLE) && enable_i;
    assign res_valid_o = (state_q == S_OUT);
    assign busy_o      = (state_q != S_OFF) && (state_q != S_IDLE);
    assign data_n_o    = '0;

    genvar gi;
    generate
        for (gi = 0; gi < numRows; gi++) begin : g_lane
            logic [xBits-1:0] lane_x;
            assign lane_x       = x_q[gi*xBits +: xBits];
            assign data_p_o[gi] = (state_q == S_DRIVE) & lane_x[k_q];
        end
    endgenerate

`ifdef QRACC_SEQ_SAT_EN
    logic [numCols-1:0] clip;
    logic               sat_q;
`endif

    generate
        for (gi = 0; gi < numCols; gi++) begin : g_col
            qracc_shift_acc #(
                .adcBits   (numAdcBits),
                .accBits   (accBits),
                .shiftBits (KW)
`ifdef QRACC_SEQ_SAT_EN
                , .outBits (outBits)
`endif
            ) u_acc (
                .clk     (clk),
                .nrst    (nrst),
                .clr_i   (acc_clr),
                .en_i    (acc_en),
                .sub_i   (acc_sub),
                .shift_i (k_q),
                .adc_i   (adc_i[gi*numAdcBits +: numAdcBits]),
`ifdef QRACC_SEQ_SAT_EN
                .res_o   (res_data_o[gi*ResW +: ResW]),
                .clip_o  (clip[gi])
`else
                .res_o   (res_data_o[gi*ResW +: ResW])
`endif
            );
        end
    endgenerate

`ifdef QRACC_SEQ_SAT_EN
    // Flag is visible as soon as the clipped result is presented and stays
    // set until the next vector is accepted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                              sat_q <= 1'b0;
        else if (acc_clr)                       sat_q <= 1'b0;
        else if (state_q == S_OUT && |clip)     sat_q <= 1'b1;
    end
    assign sat_o = sat_q | ((state_q == S_OUT) && |clip);
`endif

endmodule

// File: tb/tb_qracc_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_qracc_mac_sequencer
//   Table-driven vectors with hand-computed column sums, plus hand-written
//   sequences for settle timing, result back-pressure, simultaneous
//   handshakes and reset during a plane walk.
// -----------------------------------------------------------------------------
module tb_qracc_mac_sequencer;

    localparam int NR = 128;
    localparam int NC = 32;
    localparam int XB = 4;
    localparam int AB = 4;
`ifdef QRACC_SEQ_SAT_EN
    localparam int RW = 4;
`else
    localparam int RW = 9;
`endif

    logic               clk = 1'b0;
    logic               nrst = 1'b0;
    logic               enable_i = 1'b0;
    logic [7:0]         n_input_bits_cfg = '0;
    logic               signed_cfg = 1'b0;
    logic               x_valid_i = 1'b0;
    logic               x_ready_o;
    logic [NR*XB-1:0]   x_data_i = '0;
    logic               mac_en_o;
    logic [NR-1:0]      data_p_o;
    logic [NR-1:0]      data_n_o;
    logic [NC*AB-1:0]   adc_i = '0;
    logic               res_valid_o;
    logic               res_ready_i = 1'b0;
    logic [NC*RW-1:0]   res_data_o;
    logic               busy_o;
`ifdef QRACC_SEQ_SAT_EN
    logic               sat_o;
`endif

`ifdef QRACC_SEQ_SAT_EN
    qracc_mac_sequencer #(.outBits(4)) dut (
        .clk              (clk),
        .nrst             (nrst),
        .enable_i         (enable_i),
        .n_input_bits_cfg (n_input_bits_cfg),
        .signed_cfg       (signed_cfg),
        .x_valid_i        (x_valid_i),
        .x_ready_o        (x_ready_o),
        .x_data_i         (x_data_i),
        .mac_en_o         (mac_en_o),
        .data_p_o         (data_p_o),
        .data_n_o         (data_n_o),
        .adc_i            (adc_i),
        .res_valid_o      (res_valid_o),
        .res_ready_i      (res_ready_i),
        .res_data_o       (res_data_o),
        .sat_o            (sat_o),
        .busy_o           (busy_o)
    );
`else
    qracc_mac_sequencer dut (
        .clk              (clk),
        .nrst             (nrst),
        .enable_i         (enable_i),
        .n_input_bits_cfg (n_input_bits_cfg),
        .signed_cfg       (signed_cfg),
        .x_valid_i        (x_valid_i),
        .x_ready_o        (x_ready_o),
        .x_data_i         (x_data_i),
        .mac_en_o         (mac_en_o),
        .data_p_o         (data_p_o),
        .data_n_o         (data_n_o),
        .adc_i            (adc_i),
        .res_valid_o      (res_valid_o),
        .res_ready_i      (res_ready_i),
        .res_data_o       (res_data_o),
        .busy_o           (busy_o)
    );
`endif

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] ncfg;
        logic       sgn;
        int         code;      // ADC code on even columns
        logic       alt;       // odd columns get -code
        int         exp_lat;   // cycles accept -> res_valid
        int         exp_sum;   // even-column sum (odd = -exp_sum when alt)
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clip_val(input int v);
`ifdef QRACC_SEQ_SAT_EN
        if (v > 7)  return 7;
        if (v < -8) return -8;
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_x();
        for (int i = 0; i < NR*XB/32; i++) x_data_i[i*32 +: 32] = $urandom();
    endtask

    task automatic set_adc(input int code, input logic alt);
        logic [AB-1:0] cc;
        for (int c = 0; c < NC; c++) begin
            cc = (alt && (c % 2 == 1)) ? AB'(-code) : AB'(code);
            adc_i[c*AB +: AB] = cc;
        end
    endtask

    // Accept one vector from IDLE and stop once res_valid_o is seen.
    task automatic run_vec(input vec_t v, input string tag);
        logic [NR*XB-1:0] x_snap;
        logic signed [RW-1:0] col;
        int lat, plane_bad, e;
        logic sat_exp;
        check({tag, ".ready"}, x_ready_o, 1);
        rand_x();
        x_snap = x_data_i;
        n_input_bits_cfg = v.ncfg;
        signed_cfg = v.sgn;
        set_adc(v.code, v.alt);
        x_valid_i = 1'b1;
        tick();
        x_valid_i = 1'b0;
        // Config and data changes after accept must be ignored.
        n_input_bits_cfg = 8'd1;
        signed_cfg = ~v.sgn;
        rand_x();
        lat = 0;
        plane_bad = 0;
        while (!res_valid_o && lat < 50) begin
            for (int r = 0; r < NR; r++)
                if (lat >= XB || data_p_o[r] !== x_snap[r*XB + lat]) plane_bad++;
            if (data_n_o !== '0) plane_bad++;
            tick();
            lat++;
        end
        $display("vec %s ncfg=%0d sgn=%0d code=%0d lat=%0d col0=%0d", tag, v.ncfg, v.sgn,
                 v.code, lat, $signed(res_data_o[RW-1:0]));
        check({tag, ".latency"}, lat, v.exp_lat);
        check({tag, ".planes"}, plane_bad, 0);
        check({tag, ".idle_drive"}, (data_p_o == '0) ? 1 : 0, 1);
        sat_exp = 1'b0;
        for (int c = 0; c < NC; c++) begin
            e = (v.alt && (c % 2 == 1)) ? -v.exp_sum : v.exp_sum;
            if (clip_val(e) != e) sat_exp = 1'b1;
            col = res_data_o[c*RW +: RW];
            check($sformatf("%s.col%0d", tag, c), int'(col), clip_val(e));
        end
`ifdef QRACC_SEQ_SAT_EN
        check({tag, ".sat"}, sat_o, sat_exp);
`else
        if (sat_exp) check({tag, ".unexpected_clip"}, 1, 0);
`endif
    endtask

    task automatic finish_out(input string tag);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check({tag, ".valid_drop"}, res_valid_o, 0);
        check({tag, ".ready_back"}, x_ready_o, 1);
    endtask

    initial begin
        int cnt, bad;
        logic seen;
        logic [NC*RW-1:0] snap;

        tbl[0] = '{8'd4, 1'b1,  3, 1'b0, 4,  -3};
        tbl[1] = '{8'd4, 1'b0, -2, 1'b1, 4, -30};
        tbl[2] = '{8'd0, 1'b0,  3, 1'b0, 1,   3};
        tbl[3] = '{8'd9, 1'b1,  3, 1'b0, 4,  -3};
        tbl[4] = '{8'd1, 1'b1,  3, 1'b0, 1,  -3};
        tbl[5] = '{8'd2, 1'b0, -8, 1'b0, 2, -24};
        tbl[6] = '{8'd3, 1'b1,  7, 1'b1, 3,  -7};
        tbl[7] = '{8'd4, 1'b0,  7, 1'b0, 4, 105};
        tbl[8] = '{8'd4, 1'b1, -8, 1'b0, 4,   8};

        // Reset state
        repeat (3) tick();
        check("rst.mac_en", mac_en_o, 0);
        check("rst.x_ready", x_ready_o, 0);
        check("rst.res_valid", res_valid_o, 0);
        check("rst.busy", busy_o, 0);
        check("rst.data_p_zero", (data_p_o == '0) ? 1 : 0, 1);
        check("rst.res_zero", (res_data_o == '0) ? 1 : 0, 1);
        nrst = 1'b1;
        tick();
        check("off.mac_en", mac_en_o, 0);

        // Enable and settle
        enable_i = 1'b1;
        tick();
        $display("enable: mac_en=%0d busy=%0d", mac_en_o, busy_o);
        check("settle.mac_en", mac_en_o, 1);
        check("settle.x_ready", x_ready_o, 0);
        cnt = 0;
        while (!x_ready_o && cnt < 20) begin
            tick();
            cnt++;
        end
        $display("settle: x_ready after %0d cycles", cnt);
        check("settle.cycles", cnt, 5);

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i], $sformatf("t%0d", i));
            finish_out($sformatf("t%0d", i));
        end

        // Back-pressure: result held, no new accept while in S_OUT
        run_vec(tbl[1], "stall");
        snap = res_data_o;
        x_valid_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_data_o !== snap || x_ready_o !== 1'b0 || res_valid_o !== 1'b1) bad++;
        end
        $display("stall: 10 cycles, bad=%0d", bad);
        check("stall.stable", bad, 0);

        // Simultaneous x_valid and res_ready in S_OUT
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check("simul.valid_drop", res_valid_o, 0);
        check("simul.idle_ready", x_ready_o, 1);
        check("simul.idle_busy", busy_o, 0);
        tick();
        x_valid_i = 1'b0;
        $display("simul: accept next cycle busy=%0d", busy_o);
        check("simul.accepted", busy_o, 1);
        cnt = 0;
        while (!res_valid_o && cnt < 20) begin
            tick();
            cnt++;
        end
        check("simul.latency", cnt, 1);
        finish_out("simul");

        // Reset during plane walk
        rand_x();
        n_input_bits_cfg = 8'd4;
        signed_cfg = 1'b0;
        set_adc(5, 1'b0);
        x_valid_i = 1'b1;
        tick();
        x_valid_i = 1'b0;
        tick();
        check("abort.busy_before", busy_o, 1);
        nrst = 1'b0;
        #1;
        $display("abort: reset asserted mid-drive");
        check("abort.mac_en", mac_en_o, 0);
        check("abort.busy", busy_o, 0);
        check("abort.res_valid", res_valid_o, 0);
        check("abort.data_p_zero", (data_p_o == '0) ? 1 : 0, 1);
        check("abort.res_zero", (res_data_o == '0) ? 1 : 0, 1);
        #2;
        nrst = 1'b1;
        tick();
        seen = 1'b0;
        cnt = 0;
        while (!x_ready_o && cnt < 20) begin
            if (res_valid_o) seen = 1'b1;
            tick();
            cnt++;
        end
        check("abort.no_result", seen, 0);
        check("abort.resettled", x_ready_o, 1);

        // Disable from idle
        enable_i = 1'b0;
        tick();
        check("disable.mac_en", mac_en_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
